// File: rtl/generic_fifo_rd_prefetch_if.sv
// Output stream of the FIFO read prefetch stage: registered valid/data with
// consumer ready. The master side is the prefetch stage, the slave the consumer.
interface generic_fifo_rd_prefetch_if #(
    parameter int DAT_WIDTH = 20
);
    logic                 out_valid;
    logic                 out_ready;
    logic [DAT_WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/generic_fifo_rd_prefetch.sv
// Read-side prefetch stage for the dual-clock FIFO (read clock domain).
// Turns rd_op / rd_empty / 1-cycle RAM read data into a registered
// valid/ready stream. A 2-entry in-order skid buffer absorbs the RAM latency
// so a continuously ready consumer gets one word per cycle.
module generic_fifo_rd_prefetch #(
    parameter int DAT_WIDTH  = 20,
    parameter int RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_op,
    input  logic [DAT_WIDTH-1:0]           fifo_rd_data,
    input  logic                           flush,
    generic_fifo_rd_prefetch_if.master     out_if,
    output logic [1:0]                     out_count,
    output logic                           inflight
);

    // The landing logic below assumes read data arrives exactly one cycle
    // after the strobe; any other RAM latency is rejected at elaboration.
    generate
        if (RD_LATENCY != 1) begin : g_bad_latency
            $error("generic_fifo_rd_prefetch: only RD_LATENCY = 1 is supported");
        end
    endgenerate

    logic [DAT_WIDTH-1:0] buf0_q, buf0_d;   // head entry, drives out_data
    logic [DAT_WIDTH-1:0] buf1_q, buf1_d;   // second entry
    logic [1:0]           count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 inflight_q, inflight_d;
    logic                 drop_q, drop_d;

    logic                 pop;
    logic                 land;
    logic                 push;
    logic [2:0]           total;
    logic [2:0]           room_used;

    // Issue decision: read only when the FIFO has data, no flush is pending and
    // the words already owned (buffered + in flight, less this cycle's pop)
    // leave room for one more.
    always_comb begin
        pop        = valid_q & out_if.out_ready;
        total      = {1'b0, count_q} + {2'b00, inflight_q};
        room_used  = total - {2'b00, pop};
        fifo_rd_op = !fifo_empty && !flush && (room_used < 3'd2);
        // With one-cycle latency every outstanding read lands in the next cycle.
        land       = inflight_q;
        // A flush in the landing cycle, or a drop marked by an earlier flush,
        // discards the word: the FIFO pointer has moved on regardless.
        push       = land & !drop_q & !flush;
    end

    // Next-state for the skid buffer, occupancy, in-flight and drop tracking.
    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        count_d    = count_q;
        valid_d    = valid_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;

        // Issue sets, landing clears; an issue in the landing cycle keeps it set.
        inflight_d = fifo_rd_op | (inflight_q & !land);

        // A read still outstanding after a flush cycle must be discarded when
        // it lands. With one-cycle latency the landing coincides with the flush
        // cycle itself and is dropped through push instead.
        if (land) begin
            drop_d = 1'b0;
        end
        if (flush && inflight_q && !land) begin
            drop_d = 1'b1;
        end

        // Keep the head in buf0: pops shift buf1 forward, pushes fill the
        // first free slot after the shift.
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = fifo_rd_data;
                end else begin
                    buf1_d = fifo_rd_data;
                end
            end
            2'b01: begin
                buf0_d = buf1_q;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = fifo_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rd_data;
                end
            end
            default: begin
            end
        endcase

        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            count_d = 2'd0;
        end
        valid_d = (count_d != 2'd0);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= 2'd0;
            valid_q    <= 1'b0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Buffer overflow is unreachable through the issue rule; flag it if it occurs.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && !pop && (count_q == 2'd2)));
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = buf0_q;
    assign out_count        = count_q;
    assign inflight         = inflight_q;

endmodule

// File: tb/tb_generic_fifo_rd_prefetch.sv
// Directed bench for generic_fifo_rd_prefetch with a small FIFO/RAM model.
module tb_generic_fifo_rd_prefetch;

    localparam int DW = 20;

    logic          clk;
    logic          reset_n;
    logic          fifo_empty;
    logic          fifo_rd_op;
    logic [DW-1:0] fifo_rd_data;
    logic          flush;
    logic [1:0]    out_count;
    logic          inflight;

    generic_fifo_rd_prefetch_if #(.DAT_WIDTH(DW)) s_if ();

    generic_fifo_rd_prefetch #(.DAT_WIDTH(DW), .RD_LATENCY(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_op   (fifo_rd_op),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .out_if       (s_if),
        .out_count    (out_count),
        .inflight     (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests;
    int            fails;
    int            rd_cnt;
    int            empty_err;
    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample strobes/handshake before the edge, then advance the
    // FIFO/RAM model (read data appears the cycle after the strobe).
    task automatic tick();
        logic          rdc;
        logic          popc;
        logic [DW-1:0] dc;
        rdc  = fifo_rd_op;
        popc = s_if.out_valid && s_if.out_ready;
        dc   = s_if.out_data;
        if (rdc && fifo_empty) empty_err++;
        if (rdc) rd_cnt++;
        @(posedge clk);
        #1;
        if (popc) got.push_back(dc);
        if (rdc && q.size() > 0) fifo_rd_data = q.pop_front();
        fifo_empty = (q.size() == 0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests = 0; fails = 0; rd_cnt = 0; empty_err = 0;
        reset_n = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0; flush = 1'b0;
        s_if.out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_rd_op", {31'b0, fifo_rd_op}, 32'd0);
        check("rst_valid", {31'b0, s_if.out_valid}, 32'd0);
        check("rst_data", {12'b0, s_if.out_data}, 32'd0);
        check("rst_count", {30'b0, out_count}, 32'd0);
        check("rst_inflight", {31'b0, inflight}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick(); tick();

        // Four words, consumer always ready.
        s_if.out_ready = 1'b1; got.delete(); rd_cnt = 0;
        write_word(20'h00001); write_word(20'h00002);
        write_word(20'h00003); write_word(20'h00004);
        #1;
        check("t1_first_issue", {31'b0, fifo_rd_op}, 32'd1);
        tick();
        check("t1_lat_valid", {31'b0, s_if.out_valid}, 32'd0);
        check("t1_lat_inflight", {31'b0, inflight}, 32'd1);
        tick();
        check("t1_w1_valid", {31'b0, s_if.out_valid}, 32'd1);
        check("t1_w1_data", {12'b0, s_if.out_data}, 32'h00001);
        tick();
        check("t1_w2_data", {12'b0, s_if.out_data}, 32'h00002);
        tick();
        check("t1_w3_data", {12'b0, s_if.out_data}, 32'h00003);
        check("t1_empty_no_issue", {31'b0, fifo_rd_op}, 32'd0);
        tick();
        check("t1_w4_valid", {31'b0, s_if.out_valid}, 32'd1);
        check("t1_w4_data", {12'b0, s_if.out_data}, 32'h00004);
        tick();
        check("t1_drained_valid", {31'b0, s_if.out_valid}, 32'd0);
        check("t1_drained_count", {30'b0, out_count}, 32'd0);
        check("t1_rd_cnt", rd_cnt, 32'd4);
        check("t1_got_size", got.size(), 32'd4);

        // Eight words, consumer stalled: only two reads may be issued.
        s_if.out_ready = 1'b0; got.delete(); rd_cnt = 0;
        for (int k = 0; k < 8; k++) write_word(DW'(32'h10 + k));
        #1;
        repeat (5) tick();
        check("t2_rd_cnt", rd_cnt, 32'd2);
        check("t2_count", {30'b0, out_count}, 32'd2);
        check("t2_inflight", {31'b0, inflight}, 32'd0);
        check("t2_valid", {31'b0, s_if.out_valid}, 32'd1);
        check("t2_head_held", {12'b0, s_if.out_data}, 32'h10);
        check("t2_rd_op_idle", {31'b0, fifo_rd_op}, 32'd0);
        check("t2_fifo_left", q.size(), 32'd6);

        // Same stream drained with out_ready toggling every cycle.
        for (int i = 0; i < 200 && got.size() < 8; i++) begin
            s_if.out_ready = (i % 2 == 0);
            #1;
            tick();
        end
        s_if.out_ready = 1'b1;
        #1;
        repeat (4) tick();
        check("t3_got_size", got.size(), 32'd8);
        for (int k = 0; k < 8; k++) check($sformatf("t3_word%0d", k), {12'b0, got[k]}, 32'h10 + k);
        check("t3_count", {30'b0, out_count}, 32'd0);
        check("t3_valid", {31'b0, s_if.out_valid}, 32'd0);
        check("t3_empty_err", empty_err, 32'd0);

        // Single word, FIFO goes empty right after.
        rd_cnt = 0; got.delete(); s_if.out_ready = 1'b1;
        write_word(20'h00055);
        #1;
        check("t4_issue", {31'b0, fifo_rd_op}, 32'd1);
        tick();
        check("t4_no_more_rd", {31'b0, fifo_rd_op}, 32'd0);
        check("t4_inflight", {31'b0, inflight}, 32'd1);
        tick();
        check("t4_valid", {31'b0, s_if.out_valid}, 32'd1);
        check("t4_data", {12'b0, s_if.out_data}, 32'h00055);
        tick();
        check("t4_valid_gone", {31'b0, s_if.out_valid}, 32'd0);
        repeat (3) tick();
        check("t4_rd_cnt", rd_cnt, 32'd1);
        check("t4_got_size", got.size(), 32'd1);
        check("t4_empty_err", empty_err, 32'd0);

        // Flush the cycle after an issue with one word buffered.
        s_if.out_ready = 1'b0; got.delete();
        write_word(20'h00031); write_word(20'h00032); write_word(20'h000AA);
        #1;
        tick(); tick();
        check("t5_pre_count", {30'b0, out_count}, 32'd1);
        check("t5_pre_inflight", {31'b0, inflight}, 32'd1);
        flush = 1'b1;
        #1;
        check("t5_no_rd_in_flush", {31'b0, fifo_rd_op}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("t5_valid_cleared", {31'b0, s_if.out_valid}, 32'd0);
        check("t5_count_cleared", {30'b0, out_count}, 32'd0);
        check("t5_inflight_cleared", {31'b0, inflight}, 32'd0);
        s_if.out_ready = 1'b1;
        #1;
        tick(); tick();
        check("t5_next_valid", {31'b0, s_if.out_valid}, 32'd1);
        check("t5_next_data", {12'b0, s_if.out_data}, 32'h000AA);
        tick();
        check("t5_got_size", got.size(), 32'd1);
        check("t5_got_word", {12'b0, got[0]}, 32'h000AA);

        // Asynchronous reset in the middle of a stream.
        s_if.out_ready = 1'b0; got.delete();
        write_word(20'h00061); write_word(20'h00062);
        write_word(20'h00063); write_word(20'h00064);
        #1;
        tick(); tick();
        check("t6_pre_count", {30'b0, out_count}, 32'd1);
        check("t6_pre_inflight", {31'b0, inflight}, 32'd1);
        #2;
        reset_n = 1'b0;
        q.delete(); fifo_empty = 1'b1;
        #1;
        check("t6_rst_valid", {31'b0, s_if.out_valid}, 32'd0);
        check("t6_rst_data", {12'b0, s_if.out_data}, 32'd0);
        check("t6_rst_count", {30'b0, out_count}, 32'd0);
        check("t6_rst_inflight", {31'b0, inflight}, 32'd0);
        check("t6_rst_rd_op", {31'b0, fifo_rd_op}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        check("t6_post_valid", {31'b0, s_if.out_valid}, 32'd0);
        check("t6_post_data", {12'b0, s_if.out_data}, 32'd0);
        check("t6_post_count", {30'b0, out_count}, 32'd0);
        s_if.out_ready = 1'b1;
        write_word(20'h00077);
        #1;
        tick(); tick();
        check("t6_new_valid", {31'b0, s_if.out_valid}, 32'd1);
        check("t6_new_data", {12'b0, s_if.out_data}, 32'h00077);
        check("final_empty_err", empty_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
